instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage directly downstream of the program counter. Latches the current PC,
//   issues one word read to instruction memory over a req/ack handshake, and holds the
//   returned instruction, its opcode and its PC for decode under a valid/ready handshake.
//   Pulses pc_advance when decode accepts an instruction, so the PC steps once per
//   consumed instruction. Flags a sticky fault on a misaligned PC or a memory timeout.
// PARAMETERS
//   XLEN            32   address/instruction width
//   TIMEOUT_CYCLES  16   REQ cycles without mem_ack before fault (>=2)
// PORTS
//   clk          in   1     clock, rising edge
//   reset        in   1     asynchronous, active-high
//   pc_in        in   XLEN  current PC from program counter
//   flush        in   1     discard in-flight/held fetch (branch redirect)
//   mem_req      out  1     read request to instruction memory
//   mem_addr     out  XLEN  word address of request (= latched PC)
//   mem_ack      in   1     read data valid this cycle (sampled only while mem_req=1)
//   mem_rdata    in   XLEN  read data, valid when mem_ack=1
//   instr_valid  out  1     instr_out/opcode_out/pc_out valid for decode
//   instr_ready  in   1     decode accepts the held instruction
//   instr_out    out  XLEN  fetched instruction
//   opcode_out   out  7     instr_out[6:0]
//   pc_out       out  XLEN  PC of instr_out
//   pc_advance   out  1     one-cycle strobe: PC may step/redirect
//   fault        out  1     sticky fetch fault (misaligned PC or timeout)
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, every output 0, timeout count 0.
//   - FSM states IDLE, REQ, HOLD, FAULT; every transition takes effect on a rising clk edge.
//   - IDLE: latches pc_in into addr_q. pc_in[1:0]!=0 -> FAULT; otherwise -> REQ.
//   - REQ: mem_req=1, mem_addr=addr_q held stable until ack. mem_ack=1 at the edge ->
//     instr_q<=mem_rdata, pc_q<=addr_q, count<=0, -> HOLD. No ack -> count+1; the edge
//     where count reaches TIMEOUT_CYCLES-1 without ack -> FAULT.
//   - HOLD: instr_valid=1; instr_out, opcode_out and pc_out stay stable until accepted.
//     instr_ready=1 -> pc_advance=1 (combinational: instr_valid & instr_ready & !flush),
//     -> IDLE.
//   - Latency: with ack in the first REQ cycle, instr_valid rises 2 edges after IDLE is
//     entered. Steady-state throughput with 0-wait memory and ready held high: 1 instr / 3 clk.
//   - flush=1 in IDLE, REQ or HOLD: -> IDLE at next edge, instr_valid and mem_req drop,
//     pc_advance=0, count cleared. flush wins over a simultaneous mem_ack or instr_ready.
//     A late mem_ack outside REQ is ignored. Instruction memory tolerates abandoned
//     requests.
//   - FAULT: absorbing; fault=1, mem_req=0, instr_valid=0, pc_advance=0; flush is ignored;
//     only reset exits.
//   - Reset mid-request: mem_req drops asynchronously. No data is captured.
//   - instr_out/pc_out hold their last captured values outside HOLD (don't-care to
//     decode). Adders wrap modulo 2^XLEN.
// TESTING
//   1 reset, pc_in=0, ack every REQ cycle, ready=1 -> mem_addr 0,4,8..., instr_valid
//     every 3rd clk, pc_advance 1 clk each.
//   2 ack delayed 5 cycles, mem_rdata=32'h00500093 -> mem_req held 6 clk with addr
//     stable; instr_out=32'h00500093, opcode_out=7'h13.
//   3 HOLD with ready=0 for 4 clk -> outputs stable, pc_advance=0; ready=1 -> single
//     pc_advance pulse.
//   4 flush during REQ with simultaneous mem_ack -> no HOLD, IDLE next; refetch uses new
//     pc_in=32'h100.
//   5 pc_in=32'h6 -> fault=1 after IDLE edge, mem_req never asserted; never ack ->
//     fault after 16 REQ cycles.
//   6 reset asserted mid-REQ and mid-HOLD -> all outputs 0 immediately; normal fetch
//     after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the program counter and decode.
// Latches the PC, reads one word over req/ack, and holds it for decode under valid/ready.
module instruction_fetch #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [6:0]      opcode_out,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_advance,
    output logic            fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_count;

    logic w_misaligned;
    logic w_take_ack;

    assign w_misaligned = (pc_in[1:0] != 2'b00);
    // flush outranks a same-cycle ack: the returned word is dropped
    assign w_take_ack   = (r_state == S_REQ) && mem_ack && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_misaligned) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (mem_ack) begin
                    w_state_nxt = S_HOLD;
                end else if (r_count == LAST_WAIT) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_HOLD: begin
                if (flush || instr_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_instr <= '0;
            r_pc    <= '0;
            r_count <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_addr <= pc_in;
            end
            if (w_take_ack) begin
                r_instr <= mem_rdata;
                r_pc    <= r_addr;
            end
            // wraps to zero on the timeout edge, which also leaves REQ
            if ((r_state == S_REQ) && !flush && !mem_ack) begin
                r_count <= r_count + CW'(1);
            end else begin
                r_count <= '0;
            end
        end
    end

    assign mem_req     = (r_state == S_REQ);
    assign mem_addr    = r_addr;
    assign instr_valid = (r_state == S_HOLD);
    assign instr_out   = r_instr;
    assign opcode_out  = r_instr[6:0];
    assign pc_out      = r_pc;
    assign pc_advance  = instr_valid & instr_ready & ~flush;
    assign fault       = (r_state == S_FAULT);

endmodule
